kbd_ctrl: RTL and testbench

Sequencing controller for the PS/2 keyboard receiver. It pops bytes from the receiver FIFO using the ready/nextdata_n handshake and decodes the make, break (F0) and extended (E0) prefixes into a held-key state. It counts distinct key presses and drives the eight seven-segment digits. It sits in `top` between `ps2_keyboard` and the `seg0`..`seg7` outputs.

---
 rtl/kbd_ctrl.sv | 159 +++++++++++++++
 tb/tb_kbd_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: PS/2 FIFO pop sequencer, make/break/E0 decoder, press counter and 7-segment drives.
// The ASCII lookup is compiled in only when KBD_CTRL_ASCII_EN is defined.
module kbd_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_overflow,
    output logic       kb_nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_down,
    output logic [7:0] key_ascii,
    output logic [7:0] press_cnt,
    output logic       ovf_seen,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [7:0] seg4,
    output logic [7:0] seg5,
    output logic [7:0] seg6,
    output logic [7:0] seg7
);
    // state   | meaning
    // ST_IDLE | wait for FIFO non-empty; head byte latched on exit
    // ST_POP  | pop strobe low for one cycle; latched byte decoded
    // ST_WAIT | FIFO read pointer settles before the head is sampled again
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_POP = 2'd1, ST_WAIT = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       brk_q, brk_d;
    logic       extp_q, extp_d;
    logic [7:0] code_q, code_d;
    logic       kext_q, kext_d;
    logic       down_q, down_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            byte_q  <= 8'h00;
            brk_q   <= 1'b0;
            extp_q  <= 1'b0;
            code_q  <= 8'h00;
            kext_q  <= 1'b0;
            down_q  <= 1'b0;
            cnt_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            brk_q   <= brk_d;
            extp_q  <= extp_d;
            code_q  <= code_d;
            kext_q  <= kext_d;
            down_q  <= down_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        brk_d   = brk_q;
        extp_d  = extp_q;
        code_d  = code_q;
        kext_d  = kext_q;
        down_d  = down_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q | kb_overflow;
        case (state_q)
            ST_IDLE: begin
                if (kb_ready) begin
                    byte_d  = kb_data;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_WAIT;
                if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (byte_q == 8'hE0) begin
                    extp_d = 1'b1;
                end else if (brk_q) begin
                    // A break only releases the key if it names the held code and prefix
                    if (byte_q == code_q && extp_q == kext_q) down_d = 1'b0;
                    brk_d  = 1'b0;
                    extp_d = 1'b0;
                end else begin
                    if (!(down_q && byte_q == code_q && extp_q == kext_q)) begin
                        code_d = byte_q;
                        kext_d = extp_q;
                        down_d = 1'b1;
                        cnt_d  = cnt_q + 8'h01;
                    end
                    extp_d = 1'b0;
                end
            end
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

`ifdef KBD_CTRL_ASCII_EN
    always_comb begin
        key_ascii = 8'h00;
        if (!kext_q) begin
            case (code_q)
                8'h1C: key_ascii = 8'h41;  8'h32: key_ascii = 8'h42;  8'h21: key_ascii = 8'h43;
                8'h23: key_ascii = 8'h44;  8'h24: key_ascii = 8'h45;  8'h2B: key_ascii = 8'h46;
                8'h34: key_ascii = 8'h47;  8'h33: key_ascii = 8'h48;  8'h43: key_ascii = 8'h49;
                8'h3B: key_ascii = 8'h4A;  8'h42: key_ascii = 8'h4B;  8'h4B: key_ascii = 8'h4C;
                8'h3A: key_ascii = 8'h4D;  8'h31: key_ascii = 8'h4E;  8'h44: key_ascii = 8'h4F;
                8'h4D: key_ascii = 8'h50;  8'h15: key_ascii = 8'h51;  8'h2D: key_ascii = 8'h52;
                8'h1B: key_ascii = 8'h53;  8'h2C: key_ascii = 8'h54;  8'h3C: key_ascii = 8'h55;
                8'h2A: key_ascii = 8'h56;  8'h1D: key_ascii = 8'h57;  8'h22: key_ascii = 8'h58;
                8'h35: key_ascii = 8'h59;  8'h1A: key_ascii = 8'h5A;
                8'h45: key_ascii = 8'h30;  8'h16: key_ascii = 8'h31;  8'h1E: key_ascii = 8'h32;
                8'h26: key_ascii = 8'h33;  8'h25: key_ascii = 8'h34;  8'h2E: key_ascii = 8'h35;
                8'h36: key_ascii = 8'h36;  8'h3D: key_ascii = 8'h37;  8'h3E: key_ascii = 8'h38;
                8'h46: key_ascii = 8'h39;  8'h29: key_ascii = 8'h20;
                default: key_ascii = 8'h00;
            endcase
        end
    end
    assign seg2 = down_q ? hex7(key_ascii[3:0]) : 8'hFF;
    assign seg3 = down_q ? hex7(key_ascii[7:4]) : 8'hFF;
`else
    assign key_ascii = 8'h00;
    assign seg2      = 8'hFF;
    assign seg3      = 8'hFF;
`endif

    assign kb_nextdata_n = (state_q != ST_POP);
    assign key_code      = code_q;
    assign key_ext       = kext_q;
    assign key_down      = down_q;
    assign press_cnt     = cnt_q;
    assign ovf_seen      = ovf_q;
    assign seg0          = down_q ? hex7(code_q[3:0]) : 8'hFF;
    assign seg1          = down_q ? hex7(code_q[7:4]) : 8'hFF;
    assign seg4          = hex7(cnt_q[3:0]);
    assign seg5          = hex7(cnt_q[7:4]);
    assign seg6          = 8'hFF;
    assign seg7          = 8'hFF;
endmodule

// File: tb/tb_kbd_ctrl.sv
// Randomized self-checking bench for kbd_ctrl: behavioural FIFO, byte-level key model, 7-seg model.
module tb_kbd_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       kb_nextdata_n;
    logic [7:0] key_code, key_ascii, press_cnt;
    logic       key_ext, key_down, ovf_seen;
    logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    kbd_ctrl dut (
        .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
        .key_code(key_code), .key_ext(key_ext), .key_down(key_down),
        .key_ascii(key_ascii), .press_cnt(press_cnt), .ovf_seen(ovf_seen),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 clk = ~clk;

`ifdef KBD_CTRL_ASCII_EN
    localparam bit ASC_EN = 1'b1;
`else
    localparam bit ASC_EN = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural FIFO: the head is popped while the strobe is low
    logic [7:0] fifo[$];
    int         pops = 0;
    int         long_low = 0;
    logic       prev_low = 1'b0;
    always @(negedge clk) begin
        if (!kb_nextdata_n) begin
            pops++;
            if (prev_low) long_low++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        prev_low = !kb_nextdata_n;
        kb_ready = (fifo.size() > 0);
        kb_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // Key model
    logic [7:0] m_code, m_cnt;
    logic       m_ext, m_down, m_brk, m_extp, m_ovf;
    logic [7:0] letters[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                               8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                               8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digits[10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] font[16]    = '{8'hC0,8'hF9,8'hA4,8'hB0,8'h99,8'h92,8'h82,8'hF8,
                               8'h80,8'h90,8'h88,8'h83,8'hC6,8'hA1,8'h86,8'h8E};

    task automatic m_reset();
        m_code = 8'h00; m_cnt = 8'h00; m_ext = 1'b0; m_down = 1'b0;
        m_brk = 1'b0; m_extp = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_extp = 1'b1;
        else if (m_brk) begin
            if (b == m_code && m_extp == m_ext) m_down = 1'b0;
            m_brk = 1'b0;
            m_extp = 1'b0;
        end else begin
            if (!(m_down && b == m_code && m_extp == m_ext)) begin
                m_code = b; m_ext = m_extp; m_down = 1'b1; m_cnt = m_cnt + 8'd1;
            end
            m_extp = 1'b0;
        end
    endtask

    function automatic logic [7:0] m_ascii();
        logic [7:0] a;
        a = 8'h00;
        if (ASC_EN && !m_ext) begin
            for (int i = 0; i < 26; i++) if (letters[i] == m_code) a = 8'h41 + 8'(i);
            for (int i = 0; i < 10; i++) if (digits[i] == m_code) a = 8'h30 + 8'(i);
            if (m_code == 8'h29) a = 8'h20;
        end
        return a;
    endfunction

    task automatic check_all(input string ctx);
        logic [7:0] a;
        a = m_ascii();
        check({ctx, ".key_code"}, key_code, m_code);
        check({ctx, ".key_ext"}, key_ext, m_ext);
        check({ctx, ".key_down"}, key_down, m_down);
        check({ctx, ".key_ascii"}, key_ascii, a);
        check({ctx, ".press_cnt"}, press_cnt, m_cnt);
        check({ctx, ".ovf_seen"}, ovf_seen, m_ovf);
        check({ctx, ".seg0"}, seg0, m_down ? font[m_code[3:0]] : 8'hFF);
        check({ctx, ".seg1"}, seg1, m_down ? font[m_code[7:4]] : 8'hFF);
        check({ctx, ".seg2"}, seg2, (m_down && ASC_EN) ? font[a[3:0]] : 8'hFF);
        check({ctx, ".seg3"}, seg3, (m_down && ASC_EN) ? font[a[7:4]] : 8'hFF);
        check({ctx, ".seg4"}, seg4, font[m_cnt[3:0]]);
        check({ctx, ".seg5"}, seg5, font[m_cnt[7:4]]);
        check({ctx, ".seg6"}, seg6, 8'hFF);
        check({ctx, ".seg7"}, seg7, 8'hFF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        fifo.push_back(b);
        m_byte(b);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string ctx);
        @(posedge clk); #1;
        resetn = 1'b0;
        m_reset();
        #2;
        check_all(ctx);
        check({ctx, ".nextdata_n"}, kb_nextdata_n, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [7:0] pool[10];
        logic [7:0] b;
        pool = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'h45, 8'hF0, 8'hE0, 8'hF0, 8'hE0, 8'h00};

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        check("rst.nextdata_n", kb_nextdata_n, 1'b1);
        resetn = 1'b1;

        // First byte: strobe low for exactly the cycle after the sampling edge
        @(posedge clk); #1;
        fifo.push_back(8'h1C);
        @(negedge clk);
        @(posedge clk); #1;
        check("first.pop_low", kb_nextdata_n, 1'b0);
        check("first.not_yet", key_down, 1'b0);
        m_byte(8'h1C);
        @(posedge clk); #1;
        check("first.pop_high", kb_nextdata_n, 1'b1);
        check_all("first");
        check("first.seg0", seg0, 8'hC6);
        check("first.seg1", seg1, 8'hF9);
        repeat (2) @(posedge clk);

        p0 = pops;
        repeat (3) send_byte(8'h1C);
        check("typematic.pops", pops - p0, 3);
        check("typematic.cnt", press_cnt, 8'h01);
        check_all("typematic");

        send_byte(8'hF0); send_byte(8'h1C);
        check_all("break1C");
        check("break1C.seg4", seg4, 8'hF9);

        send_byte(8'hE0); send_byte(8'h75);
        check_all("ext_make");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        check_all("ext_break");
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hF0); send_byte(8'h75);
        check("nonext_break.down", key_down, 1'b1);
        check_all("nonext_break");

        // Back-to-back burst exercises one-byte-per-three-cycles throughput
        p0 = pops;
        @(posedge clk); #1;
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
        m_byte(8'hE0); m_byte(8'hF0); m_byte(8'h75);
        repeat (14) @(posedge clk);
        #1;
        check("burst.pops", pops - p0, 3);
        check_all("burst");

        for (int i = 0; i < 300; i++) begin
            b = pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) b = 8'($urandom);
            send_byte(b);
            check_all("rand");
        end

        do_reset("rst2");
        for (int i = 0; i < 256; i++) begin
            send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
            if (i == 254) check("wrap.ff", press_cnt, 8'hFF);
        end
        check("wrap.00", press_cnt, 8'h00);
        check_all("wrap");

        @(posedge clk); #1 kb_overflow = 1'b1;
        @(posedge clk); #1 kb_overflow = 1'b0;
        m_ovf = 1'b1;
        check("ovf.set", ovf_seen, 1'b1);
        send_byte(8'h29);
        check_all("ovf.sticky");

        // Reset during POP: the latched byte stays in the FIFO and is re-read
        p0 = pops;
        @(posedge clk); #1;
        fifo.push_back(8'h29);
        @(negedge clk);
        @(posedge clk); #1;
        check("midpop.low", kb_nextdata_n, 1'b0);
        resetn = 1'b0;
        m_reset();
        #1;
        check_all("midpop.rst");
        check("midpop.nextdata_n", kb_nextdata_n, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        m_byte(8'h29);
        check("midpop.pops", pops - p0, 1);
        check("midpop.fifo_empty", fifo.size(), 0);
        check_all("midpop.after");

        send_byte(8'hE0);
        do_reset("lone_e0.rst");
        send_byte(8'h1C);
        check("lone_e0.ext", key_ext, 1'b0);
        check_all("lone_e0");
        send_byte(8'hF0);
        do_reset("lone_f0.rst");
        send_byte(8'h1C);
        check("lone_f0.down", key_down, 1'b1);
        check_all("lone_f0");

        check("strobe_width", long_low, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
